// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the decode_signals bundle and its bubble constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline;

    localparam int XLEN = 32;

    // addi x0,x0,0 encodes as 'h13 on RV32; this core's decode treats 'h4 as its NOP.
    localparam logic [XLEN-1:0] NOP_INSTR = 'h4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] curr_pc;
        logic [XLEN-1:0] inc_pc;
    } decode_signals;

    // What decode sees when no real instruction is available.
    localparam decode_signals BUBBLE = '{instr: NOP_INSTR, curr_pc: '0, inc_pc: '0};

endpackage

// File: rtl/fetch_buffer_if.sv
// Handshake bundle between the fetch unit, the fetch buffer and decode.
// Latency: n/a (wiring only).
// Backpressure: in_ready stalls fetch; stall holds the buffer head for decode.
// Modports: master = fetch/decode side driving the buffer, slave = the buffer.
interface fetch_buffer_if;
    import pipeline::*;

    decode_signals signals_in;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          stall;
    decode_signals signals_out;
    logic          out_valid;

    modport master (
        output signals_in, in_valid, flush, stall,
        input  in_ready, signals_out, out_valid
    );

    modport slave (
        input  signals_in, in_valid, flush, stall,
        output in_ready, signals_out, out_valid
    );
endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO decoupling instruction fetch from decode; drops everything on flush.
// Latency: one cycle from push to head; no combinational in-to-out path.
// Backpressure: in_ready = not full (registered state only); stall holds the head.
// Ports: clk, reset (async, active-high), bus (fetch_buffer_if.slave).
module fetch_buffer
    import pipeline::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    fetch_buffer_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    decode_signals mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    // Both handshakes depend only on registered count, so in_ready and
    // out_valid never combinationally depend on this cycle's inputs.
    assign bus.in_ready  = (count != FULL_CNT);
    assign bus.out_valid = (count != '0);

    // A push while full is refused even if a pop frees a slot this cycle;
    // in_ready rises the cycle after. Flush overrides both directions.
    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = bus.out_valid && !bus.stall && !bus.flush;

    assign bus.signals_out = bus.out_valid ? mem[rd_ptr] : BUBBLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: a slot is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.signals_in;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
    import pipeline::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_buffer_if bus();

    fetch_buffer #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // Apply current inputs at the next rising edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc);
        bus.in_valid           = vld;
        bus.signals_in.instr   = 32'h0000_0013 + pc;
        bus.signals_in.curr_pc = pc;
        bus.signals_in.inc_pc  = pc + 32'd4;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_vld"},   {31'd0, bus.out_valid},     32'd0);
        check({tag, "_instr"}, bus.signals_out.instr,      32'h4);
        check({tag, "_pc"},    bus.signals_out.curr_pc,    32'h0);
        check({tag, "_inc"},   bus.signals_out.inc_pc,     32'h0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_vld"},   {31'd0, bus.out_valid},     32'd1);
        check({tag, "_pc"},    bus.signals_out.curr_pc,    pc);
        check({tag, "_instr"}, bus.signals_out.instr,      32'h0000_0013 + pc);
        check({tag, "_inc"},   bus.signals_out.inc_pc,     pc + 32'd4);
    endtask

    initial begin
        reset     = 1'b1;
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        check_bubble("rst");
        check("rst_rdy", {31'd0, bus.in_ready}, 32'd1);
        #1 reset = 1'b0;

        // Single pass: one-cycle latency, then drained back to bubble.
        drive(1'b1, 32'h100);
        #1;
        check("single_nocomb", {31'd0, bus.out_valid}, 32'd0);
        step();
        drive(1'b0, 32'h0);
        check_head("single", 32'h100);
        step();
        check_bubble("single_empty");

        // Empty pop request with stall low is ignored.
        step();
        check_bubble("empty_pop");

        // Fill and stall: third push refused, head holds.
        bus.stall = 1'b1;
        drive(1'b1, 32'h0);
        step();
        check("fill1_rdy", {31'd0, bus.in_ready}, 32'd1);
        check_head("fill1", 32'h0);
        drive(1'b1, 32'h4);
        step();
        check("fill2_rdy", {31'd0, bus.in_ready}, 32'd0);
        check_head("fill2", 32'h0);
        drive(1'b1, 32'h8);
        step();
        check("fill3_rdy", {31'd0, bus.in_ready}, 32'd0);
        check_head("fill3", 32'h0);
        drive(1'b0, 32'h0);

        // Drain order; 0x8 must never surface.
        bus.stall = 1'b0;
        step();
        check_head("drain1", 32'h4);
        check("drain1_rdy", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_bubble("drain2");
        check("drain2_rdy", {31'd0, bus.in_ready}, 32'd1);

        // Flush with concurrent push while stalled and full.
        bus.stall = 1'b1;
        drive(1'b1, 32'h10);
        step();
        drive(1'b1, 32'h14);
        step();
        check("preflush_rdy", {31'd0, bus.in_ready}, 32'd0);
        bus.flush = 1'b1;
        drive(1'b1, 32'h40);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0);
        check_bubble("flush");
        check("flush_rdy", {31'd0, bus.in_ready}, 32'd1);
        bus.stall = 1'b0;
        step();
        check_bubble("flush_after");

        // Push accepted right after a flush.
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b1, 32'h44);
        step();
        drive(1'b0, 32'h0);
        check_head("postflush", 32'h44);
        step();
        check_bubble("postflush_empty");

        // Wrap-around: back-to-back push/pop keeps count at 1.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i * 4));
            step();
            check_head($sformatf("wrap%0d", i), 32'(i * 4));
            check($sformatf("wrap%0d_rdy", i), {31'd0, bus.in_ready}, 32'd1);
        end
        drive(1'b0, 32'h0);
        step();
        check_bubble("wrap_end");

        // Async reset between edges with two entries queued.
        bus.stall = 1'b1;
        drive(1'b1, 32'h50);
        step();
        drive(1'b1, 32'h54);
        step();
        drive(1'b0, 32'h0);
        check("prerst_rdy", {31'd0, bus.in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check_bubble("arst");
        check("arst_rdy", {31'd0, bus.in_ready}, 32'd1);
        #1 reset = 1'b0;
        drive(1'b1, 32'h60);
        step();
        drive(1'b0, 32'h0);
        check_head("post_rst", 32'h60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
